// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants shared by the sync generator and its users.
// Module-level parameters take their defaults from here; derived values follow from them.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam logic DEF_SYNC_ACTIVE = 1'b0;
  localparam int   DEF_CW          = 10;

endpackage

// File: rtl/vga_sync_gen_edge_tick.sv
// Rising-edge detector: turns the divided pixel clock (already in the CLK domain)
// into a one-CLK enable. The history flop resets high so a level held high at release is not an edge.
module edge_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic tick
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  assign tick = sig_in & ~prev_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator on the system clock: pixel enable from edge_tick, H/V counters,
// and a registered decode of sync, video-active, coordinates and frame-start.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE,
  parameter int   CW          = DEF_CW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PIX_CLK_IN,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          VIDEO_ON,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          PIX_TICK,
  output logic          FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All compares are done at CW bits against these truncated constants.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          tick;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          pix_tick_q, pix_tick_d;
  logic          frame_start_q, frame_start_d;

  edge_tick u_edge_tick (
    .clk    (CLK),
    .rst_n  (RST_N),
    .sig_in (PIX_CLK_IN),
    .tick   (tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + CW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  // Decode looks at the current counters, so every output lags the counters by one CLK.
  always_comb begin
    hsync_d    = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    x_d        = h_cnt_q;
    y_d        = v_cnt_q;
    pix_tick_d = tick;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign VIDEO_ON    = video_on_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign PIX_TICK    = pix_tick_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line-level timing, a shrunken-timing instance
// (20x15 total) so whole frames, vsync and frame_start fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pix;

  always #5 clk = ~clk;

  logic       hs_b, vs_b, von_b, pt_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, von_s, pt_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_sync_gen u_big (
    .CLK(clk), .RST_N(rst_n), .PIX_CLK_IN(pix),
    .HSYNC(hs_b), .VSYNC(vs_b), .VIDEO_ON(von_b),
    .X(x_b), .Y(y_b), .PIX_TICK(pt_b), .FRAME_START(fs_b)
  );

  vga_sync_gen #(
    .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b0), .CW(10)
  ) u_small (
    .CLK(clk), .RST_N(rst_n), .PIX_CLK_IN(pix),
    .HSYNC(hs_s), .VSYNC(vs_s), .VIDEO_ON(von_s),
    .X(x_s), .Y(y_s), .PIX_TICK(pt_s), .FRAME_START(fs_s)
  );

  int total = 0;
  int passes = 0;

  int tick_seen   = 0;
  int per_cnt     = 0;
  int hs_low      = 0;
  int hs_first_x  = -1;
  int von_bad     = 0;
  int fs_b_count  = 0;
  int fs_count    = 0;
  int fs_first    = 0;
  int vs_low_s    = 0;
  int hs_low_s    = 0;
  int von_cnt_s   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One divider period: PIX_CLK_IN high 2 CLK then low 2 CLK, sampled on every falling edge.
  task automatic pix_period();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (pt_b) tick_seen++;
      if (fs_b) fs_b_count++;
      if (fs_s) begin
        fs_count++;
        if (fs_first == 0) fs_first = per_cnt + 1;
      end
      if (n == 0) pix = 1'b1;
      if (n == 2) pix = 1'b0;
    end
    per_cnt++;
    if (hs_b == 1'b0) begin
      hs_low++;
      if (hs_first_x < 0) hs_first_x = int'(x_b);
    end
    if (von_b !== ((x_b < 10'd640) && (y_b < 10'd480))) von_bad++;
    if (per_cnt <= 300) begin
      if (vs_s == 1'b0) vs_low_s++;
      if (hs_s == 1'b0) hs_low_s++;
      if (von_s == 1'b1) von_cnt_s++;
    end
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n; i++) pix_period();
  endtask

  initial begin
    rst_n = 1'b0;
    pix   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x",        x_b,  0);
    check("rst_y",        y_b,  0);
    check("rst_hsync",    hs_b, 1);
    check("rst_vsync",    vs_b, 1);
    check("rst_video_on", von_b, 0);
    check("rst_pix_tick", pt_b, 0);
    check("rst_frame_st", fs_s, 0);

    // Release with the divided clock already high: no spurious tick.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pt_b) tick_seen++;
    end
    check("hold_no_tick",  tick_seen, 0);
    check("hold_x",        x_b,  0);
    check("hold_y",        y_b,  0);
    check("hold_hsync",    hs_b, 1);
    check("hold_vsync",    vs_b, 1);
    check("hold_video_on", von_b, 1);

    @(negedge clk) pix = 1'b0;
    repeat (2) @(negedge clk);

    pix_period();
    check("first_tick_cnt", tick_seen, 1);
    check("first_x",        x_b, 1);
    check("first_y",        y_b, 0);
    check("first_video_on", von_b, 1);

    run_periods(798);
    check("eol_x",        x_b, 799);
    check("eol_y",        y_b, 0);
    check("eol_video_on", von_b, 0);
    check("eol_hsync",    hs_b, 1);

    pix_period();
    check("wrap_x",        x_b, 0);
    check("wrap_y",        y_b, 1);
    check("hs_low_ticks",  hs_low, 96);
    check("hs_first_x",    hs_first_x, 656);
    check("ticks_800",     tick_seen, 800);

    check("s_vs_low_ticks", vs_low_s, 40);
    check("s_hs_low_ticks", hs_low_s, 45);
    check("s_video_on_cnt", von_cnt_s, 80);
    check("s_fs_first",     fs_first, 300);
    check("s_fs_count_800", fs_count, 2);

    // Stall the pixel clock low mid-line.
    run_periods(300);
    check("pre_stall_x", x_b, 300);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pt_b) tick_seen++;
    end
    check("stall_ticks", tick_seen, 1100);
    check("stall_x",     x_b, 300);
    check("stall_y",     y_b, 1);
    pix_period();
    check("resume_x",    x_b, 301);

    run_periods(99);
    check("x_400",     x_b, 400);
    check("ticks_1200", tick_seen, 1200);
    run_periods(47);
    check("pre_rst_x",   x_b, 447);
    check("s_pre_rst_x", x_s, 7);
    check("s_pre_rst_y", y_s, 2);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x",        x_b,  0);
    check("arst_y",        y_b,  0);
    check("arst_hsync",    hs_b, 1);
    check("arst_video_on", von_b, 0);
    check("arst_s_x",      x_s,  0);
    check("arst_s_y",      y_s,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix_period();
    check("post_rst_x",   x_b, 1);
    check("post_rst_y",   y_b, 0);
    check("post_rst_s_x", x_s, 1);
    check("post_rst_s_y", y_s, 0);
    check("s_fs_count",   fs_count, 4);
    check("big_no_fs",    fs_b_count, 0);
    check("video_on_vs_xy", von_bad, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
